// File: rtl/pio_out_pulse.sv
// pio_out_pulse: parametrised Avalon-MM output PIO with atomic set/clear and a one-shot
// pulse engine that inverts selected output bits for a programmed number of clocks.
//
// Zero-wait-state slave; readdata is combinational from address. All state is updated on the
// rising edge of clk; reset is synchronous and active-high.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   address    in   [2:0] register word address
//   chipselect in   slave select
//   write_n    in   active-low write strobe (write = chipselect & ~write_n)
//   writedata  in   [31:0] write data
//   readdata   out  [31:0] combinational read data, unused upper bits read 0
//   out_port   out  [DATA_WIDTH-1:0] data register XOR active pulse mask
//   pulse_busy out  high while the pulse engine is active
//   irq        out  (only with PIO_OUT_PULSE_IRQ_EN) sticky pulse-done flag
//
// Register map:
//   0 DATA       RW  output data register
//   1 STATUS     RO  bit0 busy, bit1 done_pending (IRQ build only; write bit1=1 clears it)
//   2 PULSE_LEN  RW  pulse length in clocks
//   3 PULSE      W: trigger/retrigger/cancel mask, R: current pulse mask
//   4 OUTSET     W: data |= wd, reads 0
//   5 OUTCLEAR   W: data &= ~wd, reads 0
//   6,7          reserved
//
// Optional feature macro: PIO_OUT_PULSE_IRQ_EN adds the done_pending flag and the irq port.

module pio_out_pulse #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
`ifdef PIO_OUT_PULSE_IRQ_EN
  output logic                  irq,
`endif
  output logic                  pulse_busy
);

  // Elaboration-time parameter range checks.
  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : gen_bad_data_width
    $error("pio_out_pulse: DATA_WIDTH must be in 1..32");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : gen_bad_cnt_width
    $error("pio_out_pulse: CNT_WIDTH must be in 1..32");
  end

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrStatus = 3'd1;
  localparam logic [2:0] AddrLen    = 3'd2;
  localparam logic [2:0] AddrPulse  = 3'd3;
  localparam logic [2:0] AddrSet    = 3'd4;
  localparam logic [2:0] AddrClear  = 3'd5;

  localparam logic [DATA_WIDTH-1:0] DataRst = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0]  CntOne  = CNT_WIDTH'(1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  wr;
  logic                  wr_data, wr_len, wr_pulse, wr_set, wr_clear;
  logic [DATA_WIDTH-1:0] wd_field;
  logic                  wd_mask_zero;
  logic                  expire;

  // Bus write decode. Only one register can be written per cycle.
  assign wr           = chipselect & ~write_n;
  assign wr_data      = wr && (address == AddrData);
  assign wr_len       = wr && (address == AddrLen);
  assign wr_pulse     = wr && (address == AddrPulse);
  assign wr_set       = wr && (address == AddrSet);
  assign wr_clear     = wr && (address == AddrClear);
  assign wd_field     = writedata[DATA_WIDTH-1:0];
  assign wd_mask_zero = (wd_field == '0);

  // Data register: plain load, atomic set, atomic clear.
  always_comb begin
    data_d = data_q;
    if (wr_data) begin
      data_d = wd_field;
    end else if (wr_set) begin
      data_d = data_q | wd_field;
    end else if (wr_clear) begin
      data_d = data_q & ~wd_field;
    end
  end

  // Pulse length only affects the next (re)trigger; the running count is independent.
  always_comb begin
    len_d = len_q;
    if (wr_len) begin
      len_d = writedata[CNT_WIDTH-1:0];
    end
  end

  // Pulse engine. A PULSE write always wins over counter expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    expire  = 1'b0;
    case (state_q)
      StIdle: begin
        if (wr_pulse && !wd_mask_zero && (len_q != '0)) begin
          mask_d  = wd_field;
          cnt_d   = len_q;
          state_d = StActive;
        end
      end
      StActive: begin
        if (wr_pulse && wd_mask_zero) begin
          // Cancel: drop the inversion immediately, no done indication.
          mask_d  = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (wr_pulse && (len_q != '0)) begin
          // Retrigger: new mask, full reload.
          mask_d = wd_field;
          cnt_d  = len_q;
        end else if (cnt_q == CntOne) begin
          // Natural expiry after exactly len cycles of visible inversion.
          mask_d  = '0;
          cnt_d   = '0;
          state_d = StIdle;
          expire  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        mask_d  = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= DataRst;
      mask_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIO_OUT_PULSE_IRQ_EN
  logic done_q, done_d;
  logic wr_status;

  assign wr_status = wr && (address == AddrStatus);

  // Sticky done flag; a same-cycle expiry beats a software clear.
  always_comb begin
    done_d = done_q;
    if (expire) begin
      done_d = 1'b1;
    end else if (wr_status && writedata[1]) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign irq = done_q;
`else
  logic unused_expire;
  assign unused_expire = expire;
`endif

  // Combinational read mux.
  always_comb begin
    readdata = '0;
    case (address)
      AddrData:   readdata[DATA_WIDTH-1:0] = data_q;
      AddrStatus: begin
        readdata[0] = (state_q == StActive);
`ifdef PIO_OUT_PULSE_IRQ_EN
        readdata[1] = done_q;
`endif
      end
      AddrLen:    readdata[CNT_WIDTH-1:0]  = len_q;
      AddrPulse:  readdata[DATA_WIDTH-1:0] = mask_q;
      default:    readdata = '0;
    endcase
  end

  assign out_port   = data_q ^ mask_q;
  assign pulse_busy = (state_q == StActive);

endmodule

// File: doc/pio_out_pulse.md
Name: pio_out_pulse

Overview:
- Parametrised Avalon-MM output PIO that supersedes the fixed 1-bit output port.
- Adds configurable width, atomic set/clear of individual bits, and a hardware one-shot pulse engine that inverts selected bits for a programmed number of clocks.
- Sits on the Nios system interconnect as a zero-wait-state slave; `out_port` drives board LEDs, strobes and control lines.

Parameters:
- DATA_WIDTH, 32, width of out_port and data register (legal range 1..32).
- RESET_VALUE, 0, reset value of the data register (only the low DATA_WIDTH bits are used).
- CNT_WIDTH, 16, width of the pulse-length register and down-counter (legal range 1..32).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  combinational read data; zero-wait-state; bits above the field width read 0.
- out_port  out  DATA_WIDTH  output pins: data_reg XOR active pulse mask.
- pulse_busy  out  1  high while the pulse engine is ACTIVE.

Behaviour:
Register map (writes take effect at the clock edge of the write cycle):
- 0 DATA: RW. Write loads data_reg with writedata[DATA_WIDTH-1:0].
- 1 STATUS: RO. bit0 = busy; bits [31:1] = 0 (see Optional Feature).
- 2 PULSE_LEN: RW. Write loads len_reg with writedata[CNT_WIDTH-1:0].
- 3 PULSE: write sets a trigger mask; read returns the current pulse_mask (0 when IDLE).
- 4 OUTSET: write sets data_reg = data_reg | wd. Reads 0.
- 5 OUTCLEAR: write sets data_reg = data_reg & ~wd. Reads 0.
- 6, 7: reserved. Writes are ignored; reads return 0.

Reset:
- data_reg = RESET_VALUE, len_reg = 0, pulse_mask = 0, cnt = 0, state = IDLE.
- Therefore out_port = RESET_VALUE and pulse_busy = 0.
- Reset asserted mid-pulse aborts the pulse at the next edge.

Output and width rules:
- out_port = data_reg ^ pulse_mask. Purely a function of registers, so it changes on the edge that captures a write.
- Bits of writedata above DATA_WIDTH are ignored.

Pulse FSM (states IDLE, ACTIVE):
- IDLE, PULSE write with mask != 0 and len_reg != 0: pulse_mask <= mask, cnt <= len_reg, go to ACTIVE.
- IDLE, PULSE write with mask == 0 or len_reg == 0: ignored; stay IDLE.
- ACTIVE, no PULSE write: if cnt == 1, clear pulse_mask and go to IDLE; else cnt <= cnt - 1.
  - Result: the inversion is visible for exactly len_reg clock cycles.
- ACTIVE, PULSE write with valid mask: retrigger. Mask is replaced and cnt reloaded from len_reg. This takes priority over expiry in the same cycle.
- ACTIVE, PULSE write with mask == 0: cancel. pulse_mask <= 0, go to IDLE at that edge.
- pulse_busy = (state == ACTIVE).
- DATA/OUTSET/OUTCLEAR writes during ACTIVE update data_reg normally; out_port reflects the new data_reg XOR the mask.
- PULSE_LEN writes during ACTIVE affect only later triggers.
- Only one write per cycle is possible, so there are no simultaneous bus events. The only concurrency is bus write vs. counter expiry, resolved as above.

Optional Feature:
- Macro: PIO_OUT_PULSE_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit).
  - Adds sticky flag done_pending = STATUS bit1, set on the edge where ACTIVE expires naturally. Cancel and retrigger do not set it.
  - irq = done_pending.
  - Writing STATUS with bit1 = 1 clears the flag. If expiry happens in the same cycle, set wins.
  - Reset clears the flag.
- When undefined: no irq port; STATUS bit1 reads 0; STATUS writes are ignored.

Test Plan:
- Reset with DATA_WIDTH=8, RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata@0=32'h000000A5, pulse_busy=0.
- Write DATA=32'hFFFF_FF3C, then OUTSET=8'h01, then OUTCLEAR=8'h0C -> out_port goes 8'h3C, 8'h3D, 8'h31; OUTSET/OUTCLEAR read 0.
- PULSE_LEN=3, data=8'h00, PULSE=8'h81 -> out_port=8'h81 for exactly 3 cycles after the write edge, then 8'h00; pulse_busy high for the same 3 cycles.
- PULSE_LEN=5, PULSE=8'h01; 2 cycles later PULSE=8'h02 -> bit0 drops, bit1 high for 5 further cycles. Then PULSE_LEN=0 and PULSE=8'hFF -> ignored, stays IDLE.
- PULSE_LEN=10, PULSE=8'h10; after 2 cycles write PULSE=0 -> immediate IDLE, out_port=data_reg. With PIO_OUT_PULSE_IRQ_EN, irq stays 0.
- With PIO_OUT_PULSE_IRQ_EN: PULSE_LEN=2, PULSE=8'h01 -> irq rises on the expiry edge; STATUS reads 32'h2; writing STATUS=32'h2 clears irq. Assert reset mid-pulse -> out_port=RESET_VALUE and irq=0 next edge.
